// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg -- shared definitions for the memory BIST.
// Holds the controller state encoding and the test pattern codes used by
// mem_bist (sequencer) and mem_bist_pattern (data generator / expected
// data pipeline).
package mem_bist_pkg;

  // Controller states: one write sweep, one read sweep and a drain of the
  // read pipeline per pattern, then DONE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Pattern codes, applied in ascending order.
  typedef logic [1:0] pat_t;

  localparam pat_t PAT_ADDR = 2'd0;      // address bits replicated
  localparam pat_t PAT_INV  = 2'd1;      // inverse of PAT_ADDR
  localparam pat_t PAT_CHK  = 2'd2;      // 0x..AA / 0x..55 checkerboard
  localparam pat_t PAT_LAST = PAT_CHK;   // final pattern of a run

endpackage

// File: rtl/mem_bist_pattern.sv
// mem_bist_pattern -- test data generator and expected-data pipeline.
// Produces the pattern word for (pattern, address) combinationally; the same
// word is used as write data and, when a read is issued, enters an
// RD_LAT-deep pipeline so it lines up with the returning read data.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   pat_i           current pattern code
//   addr_i          current memory address
//   rd_i            a read is issued this cycle
//   flush_i         drop all in-flight expected entries
//   data_o          pattern word for (pat_i, addr_i)
//   exp_o           expected read data for this cycle
//   exp_vld_o       exp_o belongs to an outstanding read
module mem_bist_pattern
  import mem_bist_pkg::*;
#(
  parameter int ADDR_SZ = 14,
  parameter int DATA_SZ = 16,
  parameter int RD_LAT  = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  pat_t               pat_i,
  input  logic [ADDR_SZ-1:0] addr_i,
  input  logic               rd_i,
  input  logic               flush_i,
  output logic [DATA_SZ-1:0] data_o,
  output logic [DATA_SZ-1:0] exp_o,
  output logic               exp_vld_o
);

  logic [DATA_SZ-1:0] data_s;
  logic [DATA_SZ-1:0] exp_q [RD_LAT];
  logic [RD_LAT-1:0]  vld_q;

  // Pattern word for the current pattern and address.
  always_comb begin
    data_s = '0;
    case (pat_i)
      PAT_ADDR: begin
        for (int i = 0; i < DATA_SZ; i++) data_s[i] = addr_i[i % ADDR_SZ];
      end
      PAT_INV: begin
        for (int i = 0; i < DATA_SZ; i++) data_s[i] = ~addr_i[i % ADDR_SZ];
      end
      PAT_CHK: begin
        // Odd addresses get ...1010 (0xAA), even addresses ...0101 (0x55).
        for (int i = 0; i < DATA_SZ; i++) data_s[i] = addr_i[0] ^ ((i % 2) == 0);
      end
      default: begin
        data_s = '0;
      end
    endcase
  end

  // Expected data / valid shift pipeline, one stage per cycle of read latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int k = 0; k < RD_LAT; k++) exp_q[k] <= '0;
    end else begin
      exp_q[0] <= data_s;
      for (int k = 1; k < RD_LAT; k++) exp_q[k] <= exp_q[k-1];
      if (flush_i) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= rd_i;
        for (int k = 1; k < RD_LAT; k++) vld_q[k] <= vld_q[k-1];
      end
    end
  end

  assign data_o    = data_s;
  assign exp_o     = exp_q[RD_LAT-1];
  assign exp_vld_o = vld_q[RD_LAT-1];

endmodule

// File: rtl/mem_bist.sv
// mem_bist -- march-style memory built-in self test.
// For each of three patterns: write every address ascending, read every
// address ascending, then drain the read pipeline. The first mismatching
// compare ends the run. A fault-free run lasts 3*(2*2^ADDR_SZ+RD_LAT) cycles.
// Optional feature macro: MEM_BIST_FAIL_CAPTURE_EN -- when defined the address
// of the first mismatch is captured on o_fail_addr; otherwise o_fail_addr is 0.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_run            level start request (ignored once a run has begun)
//   o_running        test in progress (WRITE/READ/DRAIN)
//   o_done           test finished, results valid
//   o_passed         every compare matched (valid while o_done)
//   o_fail_addr      address of the first mismatch
//   o_mem_wr/o_mem_rd/o_mem_addr/o_mem_wdata   memory command outputs
//   i_mem_rdata      memory read data, RD_LAT cycles after o_mem_rd
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter int ADDR_SZ = 14,
  parameter int DATA_SZ = 16,
  parameter int RD_LAT  = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_run,
  output logic               o_running,
  output logic               o_done,
  output logic               o_passed,
  output logic [ADDR_SZ-1:0] o_fail_addr,
  output logic               o_mem_wr,
  output logic               o_mem_rd,
  output logic [ADDR_SZ-1:0] o_mem_addr,
  output logic [DATA_SZ-1:0] o_mem_wdata,
  input  logic [DATA_SZ-1:0] i_mem_rdata
);

  localparam int CW = ADDR_SZ + 1;
  localparam logic [ADDR_SZ:0] CNT_ONE    = CW'(1);
  // The counter keeps running through DRAIN (2^ADDR_SZ .. 2^ADDR_SZ+RD_LAT-1),
  // so it doubles as the drain timer and as the compare-address reference.
  localparam logic [ADDR_SZ:0] DRAIN_LAST = CW'((2 ** ADDR_SZ) + RD_LAT - 1);

  state_e             state_q, state_d;
  logic [ADDR_SZ:0]   addr_q, addr_d, addr_inc_s;
  pat_t               pat_q, pat_d;
  logic               passed_q, passed_d;
  logic               running_q, done_q, wr_q, rd_q;
  logic [DATA_SZ-1:0] data_s, exp_s;
  logic               exp_vld_s, cmp_fail_s;

  mem_bist_pattern #(
    .ADDR_SZ (ADDR_SZ),
    .DATA_SZ (DATA_SZ),
    .RD_LAT  (RD_LAT)
  ) u_pattern (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .pat_i     (pat_q),
    .addr_i    (addr_q[ADDR_SZ-1:0]),
    .rd_i      (rd_q),
    .flush_i   (cmp_fail_s),
    .data_o    (data_s),
    .exp_o     (exp_s),
    .exp_vld_o (exp_vld_s)
  );

  assign addr_inc_s = addr_q + CNT_ONE;
  // Compares only happen while reads are outstanding (READ or DRAIN).
  assign cmp_fail_s = exp_vld_s && (i_mem_rdata != exp_s) &&
                      ((state_q == ST_READ) || (state_q == ST_DRAIN));

  // Next-state, address and pattern sequencing.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pat_d    = pat_q;
    passed_d = passed_q;
    case (state_q)
      ST_IDLE: begin
        if (i_run) begin
          state_d  = ST_WRITE;
          addr_d   = '0;
          pat_d    = PAT_ADDR;
          passed_d = 1'b1;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_WRITE: begin
        // Carry out of the address counter ends the sweep.
        if (addr_inc_s[ADDR_SZ]) begin
          state_d = ST_READ;
          addr_d  = '0;
        end else begin
          addr_d  = addr_inc_s;
        end
      end
      ST_READ: begin
        addr_d = addr_inc_s;
        if (cmp_fail_s) begin
          state_d  = ST_DONE;
          passed_d = 1'b0;
        end else if (addr_inc_s[ADDR_SZ]) begin
          state_d  = ST_DRAIN;
        end else begin
          state_d  = ST_READ;
        end
      end
      ST_DRAIN: begin
        addr_d = addr_inc_s;
        if (cmp_fail_s) begin
          state_d  = ST_DONE;
          passed_d = 1'b0;
        end else if (addr_q == DRAIN_LAST) begin
          if (pat_q == PAT_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WRITE;
            pat_d   = pat_q + 2'd1;
            addr_d  = '0;
          end
        end else begin
          state_d  = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (!i_run) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered status/command flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      pat_q     <= PAT_ADDR;
      passed_q  <= 1'b1;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pat_q     <= pat_d;
      passed_q  <= passed_d;
      running_q <= (state_d == ST_WRITE) || (state_d == ST_READ) || (state_d == ST_DRAIN);
      done_q    <= (state_d == ST_DONE);
      wr_q      <= (state_d == ST_WRITE);
      rd_q      <= (state_d == ST_READ);
    end
  end

`ifdef MEM_BIST_FAIL_CAPTURE_EN
  logic [ADDR_SZ-1:0] fail_addr_q, fail_addr_d, cmp_addr_s;

  // The data under compare was read RD_LAT cycles ago, while the counter
  // has advanced by RD_LAT since then.
  assign cmp_addr_s = ADDR_SZ'(addr_q - CW'(RD_LAT));

  // First-failure address capture, cleared when a run starts.
  always_comb begin
    fail_addr_d = fail_addr_q;
    if ((state_q == ST_IDLE) && i_run) begin
      fail_addr_d = '0;
    end else if (cmp_fail_s) begin
      fail_addr_d = cmp_addr_s;
    end else begin
      fail_addr_d = fail_addr_q;
    end
  end

  // Failure address register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fail_addr_q <= '0;
    end else begin
      fail_addr_q <= fail_addr_d;
    end
  end

  assign o_fail_addr = fail_addr_q;
`else
  assign o_fail_addr = '0;
`endif

  assign o_running   = running_q;
  assign o_done      = done_q;
  assign o_passed    = passed_q;
  assign o_mem_wr    = wr_q;
  assign o_mem_rd    = rd_q;
  assign o_mem_addr  = (wr_q || rd_q) ? addr_q[ADDR_SZ-1:0] : '0;
  assign o_mem_wdata = wr_q ? data_s : '0;

endmodule

// File: tb/tb_mem_bist.sv
// tb_mem_bist -- self-checking bench for mem_bist.
// Two DUTs (ADDR_SZ=4, DATA_SZ=8) with read latency 1 and 3, each driving a
// behavioural RAM with an optional stuck-at bit. Expected outcomes come from
// a pattern-table model of the test algorithm.
module tb_mem_bist;

  localparam int N = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       run, rst_n, running, done, passed, mwr, mrd;
  logic [1:0][3:0]  fail_addr, maddr;
  logic [1:0][7:0]  wdata, rdata;

  logic [1:0] fen, fv;
  int         fa [2];
  int         fb [2];
  int         wcnt [2];
  int         rcnt [2];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pattern table: p0 address nibble repeated, p1 its inverse, p2 checkerboard.
  function automatic logic [7:0] pat_val(input int p, input int a);
    logic [7:0] base;
    base = 8'(((a % 16) * 16) + (a % 16));
    if (p == 0) return base;
    else if (p == 1) return ~base;
    else return ((a % 2) == 1) ? 8'hAA : 8'h55;
  endfunction

  // Value the faulty RAM of instance g holds after writing v to address a.
  function automatic logic [7:0] stored(input int g, input int a, input logic [7:0] v);
    logic [7:0] m;
    m = 8'(1 << fb[g]);
    if (fen[g] && (a == fa[g])) return fv[g] ? (v | m) : (v & ~m);
    return v;
  endfunction

  // Outcome of a whole run: first pattern/address whose read-back differs.
  task automatic model(input int g, output bit ep, output int efa, output int ecyc);
    int lat;
    lat  = (g == 0) ? 1 : 3;
    ep   = 1'b1;
    efa  = 0;
    ecyc = 3 * (2 * N + lat);
    for (int p = 0; p < 3; p++) begin
      for (int a = 0; a < N; a++) begin
        if (ep && (stored(g, a, pat_val(p, a)) != pat_val(p, a))) begin
          ep   = 1'b0;
          efa  = a;
          ecyc = p * (2 * N + lat) + N + a + lat + 1;
        end
      end
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [7:0] mem [16];
    logic [7:0] rp  [LAT];

    mem_bist #(.ADDR_SZ(4), .DATA_SZ(8), .RD_LAT(LAT)) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n[g]),
      .i_run       (run[g]),
      .o_running   (running[g]),
      .o_done      (done[g]),
      .o_passed    (passed[g]),
      .o_fail_addr (fail_addr[g]),
      .o_mem_wr    (mwr[g]),
      .o_mem_rd    (mrd[g]),
      .o_mem_addr  (maddr[g]),
      .o_mem_wdata (wdata[g]),
      .i_mem_rdata (rdata[g])
    );

    always @(posedge clk) begin
      if (mwr[g]) mem[maddr[g]] <= stored(g, int'(maddr[g]), wdata[g]);
      rp[0] <= mem[maddr[g]];
      for (int k = 1; k < LAT; k++) rp[k] <= rp[k-1];
    end
    assign rdata[g] = rp[LAT-1];

    always @(negedge clk) begin
      check("wr_rd_excl", 32'({mwr[g] & mrd[g], (mwr[g] | mrd[g]) & ~running[g]}), 32'd0);
      if (mwr[g]) begin
        check("wr_addr", 32'(maddr[g]), wcnt[g] % N);
        check("wr_data", 32'(wdata[g]), 32'(pat_val(wcnt[g] / N, wcnt[g] % N)));
        wcnt[g]++;
      end
      if (mrd[g]) begin
        check("rd_addr", 32'(maddr[g]), rcnt[g] % N);
        rcnt[g]++;
      end
    end
  end

  task automatic run_and_check(input int g, input string tag, input bit drop);
    bit ep, seen;
    int efa, ecyc, cnt;
    model(g, ep, efa, ecyc);
    wcnt[g] = 0;
    rcnt[g] = 0;
    @(negedge clk);
    run[g] = 1'b1;
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; (i < 1000) && !seen; i++) begin
      @(negedge clk);
      if (running[g]) cnt++;
      if (drop && (cnt == 10)) run[g] = 1'b0;
      if (done[g]) seen = 1'b1;
    end
    check({tag, "_timeout"}, 32'(seen), 32'd1);
    check({tag, "_cycles"}, cnt, ecyc);
    check({tag, "_passed"}, 32'(passed[g]), 32'(ep));
`ifdef MEM_BIST_FAIL_CAPTURE_EN
    check({tag, "_fail_addr"}, 32'(fail_addr[g]), efa);
`else
    check({tag, "_fail_addr"}, 32'(fail_addr[g]), 32'd0);
`endif
    check({tag, "_not_running"}, 32'(running[g]), 32'd0);
    run[g] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_idle"}, 32'(done[g]), 32'd0);
    check({tag, "_passed_hold"}, 32'(passed[g]), 32'(ep));
  endtask

  task automatic check_reset_outputs(input int g, input string tag);
    check({tag, "_flags"}, 32'({running[g], done[g], mwr[g], mrd[g]}), 32'd0);
    check({tag, "_passed"}, 32'(passed[g]), 32'd1);
    check({tag, "_bus"}, 32'({fail_addr[g], maddr[g], wdata[g]}), 32'd0);
  endtask

  initial begin
    int cnt;
    run   = 2'b00;
    rst_n = 2'b00;
    fen   = 2'b00;
    fv    = 2'b00;
    for (int g = 0; g < 2; g++) begin
      fa[g] = 0; fb[g] = 0; wcnt[g] = 0; rcnt[g] = 0;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs(0, "rst0");
    check_reset_outputs(1, "rst1");
    rst_n = 2'b11;

    run_and_check(0, "ideal_l1", 1'b0);

    fen[0] = 1'b1; fa[0] = 5; fb[0] = 2; fv[0] = 1'b0;
    run_and_check(0, "stuck_a5b2", 1'b0);

    run_and_check(1, "ideal_l3", 1'b0);

    fen[0] = 1'b0;
    run_and_check(0, "drop_run", 1'b1);

    fen[1] = 1'b1; fa[1] = 9; fb[1] = 7; fv[1] = 1'b1;
    run_and_check(1, "stuck_l3", 1'b1);

    // Reset pulse in the read sweep of pattern 1.
    wcnt[0] = 0;
    rcnt[0] = 0;
    @(negedge clk);
    run[0] = 1'b1;
    cnt = 0;
    for (int i = 0; (i < 1000) && (cnt < 2 * N + 1 + N + 5); i++) begin
      @(negedge clk);
      if (running[0]) cnt++;
    end
    check("mid_in_read", 32'(mrd[0]), 32'd1);
    rst_n[0] = 1'b0;
    #1;
    check_reset_outputs(0, "mid_rst");
    @(negedge clk);
    check_reset_outputs(0, "mid_rst_hold");
    rst_n[0] = 1'b1;
    run[0]   = 1'b0;
    run_and_check(0, "rerun", 1'b0);

    for (int r = 0; r < 8; r++) begin
      int g;
      g      = int'($urandom_range(1, 0));
      fen[g] = ($urandom_range(3, 0) != 0);
      fa[g]  = int'($urandom_range(15, 0));
      fb[g]  = int'($urandom_range(7, 0));
      fv[g]  = 1'($urandom_range(1, 0));
      run_and_check(g, "rand", 1'($urandom_range(1, 0)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bist.md
MEM_BIST -- requirements
Module: mem_bist

Interface
REQ-001 SHALL have parameter ADDR_SZ, default 14, memory address width in bits (4..16).
REQ-002 SHALL have parameter DATA_SZ, default 16, memory data width in bits (4..32).
REQ-003 SHALL have parameter RD_LAT, default 1, memory read latency in cycles (1..3).
REQ-004 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_run, input, 1, level start request.
REQ-007 SHALL have port o_running, output, 1, test in progress.
REQ-008 SHALL have port o_done, output, 1, test completed, results valid.
REQ-009 SHALL have port o_passed, output, 1, all compares matched; valid while o_done=1.
REQ-010 SHALL have port o_fail_addr, output, ADDR_SZ, address of first mismatch.
REQ-011 SHALL have ports o_mem_wr (1), o_mem_rd (1), o_mem_addr (ADDR_SZ), o_mem_wdata (DATA_SZ), all outputs to the memory.
REQ-012 SHALL have port i_mem_rdata, input, DATA_SZ, memory read data, valid RD_LAT cycles after the o_mem_rd cycle.

Function
REQ-013 SHALL implement states IDLE, WRITE, READ, DRAIN, DONE.
REQ-014 IDLE->WRITE on the first cycle with i_run=1; pattern index=0, address=0.
REQ-015 WRITE: one write per cycle, o_mem_wr=1, address 0..2^ADDR_SZ-1 ascending; after the last address -> READ, address=0.
REQ-016 READ: one read per cycle, o_mem_rd=1, ascending; after the last address -> DRAIN.
REQ-017 DRAIN: exactly RD_LAT cycles; after the last compare -> next pattern (WRITE), or DONE after pattern 2.
REQ-018 Expected data SHALL be delayed with the address through an RD_LAT-deep pipeline; compare i_mem_rdata against it every cycle its valid bit is set.
REQ-019 Pattern 0: address bits replicated LSB-first to fill DATA_SZ. Example: ADDR_SZ=4, addr 5 gives DATA_SZ=8 value 0x55.
REQ-020 Pattern 1: bitwise inverse of pattern 0.
REQ-021 Pattern 2: 0x..AA when addr[0]=1, 0x..55 when addr[0]=0, width DATA_SZ.
REQ-022 Address counter SHALL be ADDR_SZ+1 bits; the carry ends the phase, with no wrap re-visit.
REQ-023 On the first mismatch: record the address, clear o_passed, abort any remaining pipelined reads, and go to DONE on the next cycle.
REQ-024 o_running=1 exactly in WRITE, READ and DRAIN.
REQ-025 o_done=1 in DONE only.
REQ-026 o_mem_wr and o_mem_rd SHALL never both be 1, and SHALL be 0 outside WRITE/READ.
REQ-027 DONE->IDLE when i_run=0; o_passed and o_fail_addr hold until the next start.
REQ-028 i_run falling mid-test SHALL be ignored; the test runs to completion.
REQ-029 Fault-free run length SHALL be 3*(2*2^ADDR_SZ+RD_LAT) cycles from WRITE entry to DONE entry.

Reset
REQ-030 While i_rst_n=0: state=IDLE, all outputs 0, o_passed=1, pipeline valid bits cleared; this applies immediately and asynchronously, including mid-test.
REQ-031 After i_rst_n rises, the first start SHALL need no extra cycles beyond REQ-014.

Configuration
REQ-032 Macro MEM_BIST_FAIL_CAPTURE_EN defined: o_fail_addr is registered per REQ-023.
REQ-033 Macro MEM_BIST_FAIL_CAPTURE_EN undefined: o_fail_addr is constant 0, with no capture register; everything else is unchanged.

Structure
REQ-034 Package mem_bist_pkg SHALL hold the state encoding and the pattern codes (PAT_ADDR, PAT_INV, PAT_CHK, PAT_LAST).
REQ-035 Sub-module mem_bist_pattern SHALL generate write/expected data from (pattern, address) and hold the RD_LAT expected-data/valid pipeline.

Verification
REQ-036 ADDR_SZ=4, DATA_SZ=8, RD_LAT=1, ideal RAM, i_run=1 -> o_done after 99 running cycles; o_passed=1.
REQ-037 Same setup, addr 5 bit 2 stuck-at-0 -> pattern 0 read mismatch; o_passed=0, o_fail_addr=5, o_done one cycle after the compare.
REQ-038 RD_LAT=3, ideal RAM -> o_passed=1, 3*(32+3)=105 running cycles, no spurious compare during DRAIN.
REQ-039 i_rst_n pulsed low during READ of pattern 1 -> outputs zero, o_passed=1 immediately; re-run passes.
REQ-040 Macro undefined, stuck-bit RAM -> o_passed=0, o_fail_addr=0; i_run dropped mid-test -> run still completes.
